// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the data-memory arbiter.
//   - DEF_ADDR_W / DEF_DATA_W : default memory geometry (2048 x 16)
//   - arb_state_t             : arbiter FSM states
//   - PORT_A / PORT_B         : port identifiers used for grants and the
//                               round-robin last-grant pointer
//   - grant_state()           : first transfer state for a granted port
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_XFER = 2'd1,
        B_HI   = 2'd2,
        B_LO   = 2'd3
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Port B starts with the high word; port A is a single access.
    function automatic arb_state_t grant_state(input logic port);
        return (port == PORT_B) ? B_HI : A_XFER;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
//   Combinational winner select between the two requesters.
//   Build option: ARB_ROUND_ROBIN_EN
//     defined     : on a simultaneous request the port NOT granted last wins
//     not defined : fixed priority, port B beats port A
// Ports
//   a_vld_i      in  1  port A eligible (request and not in its done cycle)
//   b_vld_i      in  1  port B eligible
//   last_grant_i in  1  port granted most recently (PORT_A / PORT_B)
//   grant_vld_o  out 1  some port is eligible
//   grant_port_o out 1  winning port id
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic a_vld_i,
    input  logic b_vld_i,
    input  logic last_grant_i,
    output logic grant_vld_o,
    output logic grant_port_o
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_vld_o  = a_vld_i | b_vld_i;
        grant_port_o = PORT_A;
        if (a_vld_i && b_vld_i) begin
            // Contention: favour whoever was not served last.
            grant_port_o = (last_grant_i == PORT_A) ? PORT_B : PORT_A;
        end else if (b_vld_i) begin
            grant_port_o = PORT_B;
        end
    end
`else
    // Fixed priority has no use for the pointer.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_vld_o  = a_vld_i | b_vld_i;
        grant_port_o = b_vld_i ? PORT_B : PORT_A;
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Shares a single-port ADDR_W x DATA_W data memory between
//     port A : pipeline MEM stage, one DATA_W load/store
//     port B : stack/interrupt unit, 2*DATA_W push/pop done as two word
//              accesses, high word at b_addr, low word at b_addr+1 (wraps)
//   All memory-side outputs are registered; the controls for a transfer
//   state are loaded on the edge that enters that state.
//   Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration with a
//   1-bit last-grant pointer; otherwise fixed priority B > A.
// Ports
//   Clk, Rst          clock, synchronous active-high reset
//   a_req/we/addr/wdata  port A request (held until a_done)
//   a_done, a_rdata      port A completion pulse and load data
//   b_req/we/addr/wdata  port B request (held until b_done), wdata {hi,lo}
//   b_done, b_rdata      port B completion pulse and pop data {hi,lo}
//   mem_write/read/addr/din  memory controls
//   mem_dout             combinational memory read data
//   busy                 FSM not in IDLE
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic                  a_done,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [2*DATA_W-1:0]   b_wdata,
    output logic                  b_done,
    output logic [2*DATA_W-1:0]   b_rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  busy
);

    arb_state_t            state_q, state_d;
    logic                  a_done_q, b_done_q;
    logic [DATA_W-1:0]     a_rdata_q, a_rdata_d;
    logic [2*DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_din_q, mem_din_d;

    logic                  grant_vld, grant_port, last_grant;
    logic                  granting;

    // -----------------------------------------------------------------------
    // Arbitration. A port whose done is high this cycle has already been
    // served; its req may still be up for this cycle, so mask it out.
    // -----------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = PORT_A;
`endif

    mem_arb_pick u_pick (
        .a_vld_i      (a_req & ~a_done_q),
        .b_vld_i      (b_req & ~b_done_q),
        .last_grant_i (last_grant),
        .grant_vld_o  (grant_vld),
        .grant_port_o (grant_port)
    );

    assign granting = (state_q == IDLE) && grant_vld;

`ifdef ARB_ROUND_ROBIN_EN
    assign last_grant_d = granting ? grant_port : last_grant_q;
`endif

    // -----------------------------------------------------------------------
    // Next state and read-data capture. Read data is taken from mem_dout
    // only when the registered read strobe is up for the current state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (granting) state_d = grant_state(grant_port);
            end
            A_XFER: begin
                if (mem_read_q) a_rdata_d = mem_dout;
                state_d = IDLE;
            end
            B_HI: begin
                if (mem_read_q) b_rdata_d[2*DATA_W-1:DATA_W] = mem_dout;
                state_d = B_LO;
            end
            B_LO: begin
                if (mem_read_q) b_rdata_d[DATA_W-1:0] = mem_dout;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Memory controls for the state being entered, so they are stable for
    // the whole transfer cycle. In IDLE the strobes drop; address and data
    // simply hold.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        case (state_d)
            A_XFER: begin
                mem_write_d = a_we;
                mem_read_d  = ~a_we;
                mem_addr_d  = a_addr;
                mem_din_d   = a_wdata;
            end
            B_HI: begin
                mem_write_d = b_we;
                mem_read_d  = ~b_we;
                mem_addr_d  = b_addr;
                mem_din_d   = b_wdata[2*DATA_W-1:DATA_W];
            end
            B_LO: begin
                mem_write_d = b_we;
                mem_read_d  = ~b_we;
                mem_addr_d  = b_addr + ADDR_W'(1);  // top address wraps to 0
                mem_din_d   = b_wdata[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // State. Reset drops any transfer in flight without a done pulse; the
    // access already presented this cycle still completes at the memory.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_done_q    <= (state_q == A_XFER);
            b_done_q    <= (state_q == B_LO);
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer starts at A so the first contention goes to B.
    always_ff @(posedge Clk) begin
        if (Rst) last_grant_q <= PORT_A;
        else     last_grant_q <= last_grant_d;
    end
`endif

    assign a_done    = a_done_q;
    assign b_done    = b_done_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized run
// checked against a timestamp-level arbitration/memory model.
module tb_data_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        a_req, a_we;
    logic [10:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_done;
    logic [15:0] a_rdata;
    logic        b_req, b_we;
    logic [10:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_done;
    logic [31:0] b_rdata;
    logic        mem_write, mem_read;
    logic [10:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    data_mem_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    // Single-port memory: combinational read, write on falling edge.
    logic [15:0] mem [0:2047];
    int          wr_cnt = 0;
    assign mem_dout = mem[mem_addr];
    always @(negedge Clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_din;
            wr_cnt++;
        end
    end

    logic [15:0] ref_mem [int];

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic do_reset();
        Rst = 1; a_req = 0; b_req = 0;
        repeat (2) @(posedge Clk);
        #1 Rst = 0;
    endtask

    task automatic do_a(input logic we, input logic [10:0] addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd);
        a_req = 1; a_we = we; a_addr = addr; a_wdata = wd;
        lat = -1; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk); #1;
            if (a_done) begin lat = c; rd = a_rdata; break; end
        end
        a_req = 0;
        @(posedge Clk); #1;
    endtask

    task automatic do_b(input logic we, input logic [10:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
        b_req = 1; b_we = we; b_addr = addr; b_wdata = wd;
        lat = -1; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk); #1;
            if (b_done) begin lat = c; rd = b_rdata; break; end
        end
        b_req = 0;
        @(posedge Clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Rst = 1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge Clk);
        #1;
        n_tests++;
        if ({busy, a_done, b_done, mem_write, mem_read} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 00000", {busy, a_done, b_done, mem_write, mem_read});
        end
        n_tests++;
        if ({mem_addr, mem_din} !== 27'd0) begin
            n_fail++; $display("FAIL reset_mem_bus got addr=%h din=%h want 0", mem_addr, mem_din);
        end
        n_tests++;
        if ({a_rdata, b_rdata} !== 48'd0) begin
            n_fail++; $display("FAIL reset_rdata got a=%h b=%h want 0", a_rdata, b_rdata);
        end
        Rst = 0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk); #1;
            n_tests++;
            if ({mem_read, mem_write, busy} !== 3'b000) begin
                n_fail++; $display("FAIL idle_c%0d got rd/wr/busy=%b want 000", c, {mem_read, mem_write, busy});
            end
        end
    endtask

    task automatic test_a_store_load();
        int lat, w0;
        logic [15:0] rd;
        w0 = wr_cnt;
        do_a(1, 11'h010, 16'h1234, lat, rd);
        n_tests++;
        if (lat != 2) begin n_fail++; $display("FAIL a_store_lat got %0d want 2", lat); end
        n_tests++;
        if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL a_store_wr_cycles got %0d want 1", wr_cnt - w0); end
        w0 = wr_cnt;
        do_a(0, 11'h010, 16'h0000, lat, rd);
        n_tests++;
        if (lat != 2) begin n_fail++; $display("FAIL a_load_lat got %0d want 2", lat); end
        n_tests++;
        if (rd !== 16'h1234) begin n_fail++; $display("FAIL a_load_data got %h want 1234", rd); end
        n_tests++;
        if (wr_cnt != w0) begin n_fail++; $display("FAIL a_load_wr_cycles got %0d want 0", wr_cnt - w0); end
        // A store must leave the last load data untouched.
        do_a(1, 11'h011, 16'h5555, lat, rd);
        n_tests++;
        if (a_rdata !== 16'h1234) begin n_fail++; $display("FAIL a_rdata_after_store got %h want 1234", a_rdata); end
        n_tests++;
        if (mem[11'h011] !== 16'h5555) begin n_fail++; $display("FAIL a_store2_mem got %h want 5555", mem[11'h011]); end
    endtask

    task automatic test_b_push_pop();
        int lat;
        logic [31:0] rd;
        do_b(1, 11'h100, 32'hDEADBEEF, lat, rd);
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL b_push_lat got %0d want 3", lat); end
        n_tests++;
        if ({mem[11'h100], mem[11'h101]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL b_push_mem got %h_%h want DEAD_BEEF", mem[11'h100], mem[11'h101]);
        end
        do_b(0, 11'h100, 32'h0, lat, rd);
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL b_pop_lat got %0d want 3", lat); end
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b_pop_data got %h want DEADBEEF", rd); end
    endtask

    task automatic test_b_wrap();
        int lat;
        logic [31:0] rd;
        do_b(1, 11'h7FF, 32'hCAFEF00D, lat, rd);
        n_tests++;
        if (mem[11'h7FF] !== 16'hCAFE) begin n_fail++; $display("FAIL wrap_hi got %h want CAFE", mem[11'h7FF]); end
        n_tests++;
        if (mem[11'h000] !== 16'hF00D) begin n_fail++; $display("FAIL wrap_lo got %h want F00D", mem[11'h000]); end
        do_b(0, 11'h7FF, 32'h0, lat, rd);
        n_tests++;
        if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_pop got %h want CAFEF00D", rd); end
    endtask

    // Both ports rise together and each re-requests one cycle after its
    // done: expected service order B,A,B,A at cycles 3,5,8,10.
    task automatic test_contention();
        int  a_left, b_left, times[$];
        bit  a_rr, b_rr;
        byte ord[$];
        int  exp_t[4] = '{3, 5, 8, 10};
        byte exp_o[4] = '{"B", "A", "B", "A"};
        do_reset();
        a_left = 2; b_left = 2; a_rr = 0; b_rr = 0;
        a_we = 1; a_addr = 11'h020; a_wdata = 16'hA5A5;
        b_we = 1; b_addr = 11'h030; b_wdata = 32'h11112222;
        a_req = 1; b_req = 1;
        for (int c = 1; c <= 40 && (a_left > 0 || b_left > 0); c++) begin
            @(posedge Clk); #1;
            if (a_rr) begin a_req = 1; a_rr = 0; end
            if (b_rr) begin b_req = 1; b_rr = 0; end
            if (a_done) begin ord.push_back("A"); times.push_back(c); a_req = 0; a_left--; a_rr = (a_left > 0); end
            if (b_done) begin ord.push_back("B"); times.push_back(c); b_req = 0; b_left--; b_rr = (b_left > 0); end
        end
        a_req = 0; b_req = 0;
        n_tests++;
        if (ord.size() != 4) begin
            n_fail++; $display("FAIL contention_count got %0d dones want 4", ord.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (ord[i] != exp_o[i] || times[i] != exp_t[i]) begin
                    n_fail++; $display("FAIL contention_%0d got %c@%0d want %c@%0d", i, ord[i], times[i], exp_o[i], exp_t[i]);
                end
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_push();
        b_req = 1; b_we = 1; b_addr = 11'h200; b_wdata = 32'h13579BDF;
        repeat (2) @(posedge Clk);
        #1;
        n_tests++;
        if (!(busy === 1'b1 && mem_write === 1'b1 && mem_addr === 11'h201)) begin
            n_fail++; $display("FAIL rstmid_in_lo got busy=%b wr=%b addr=%h want 1 1 201", busy, mem_write, mem_addr);
        end
        Rst = 1; b_req = 0;
        @(posedge Clk); #1;
        n_tests++;
        if ({busy, b_done, a_done, mem_write, mem_read} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_flags got %b want 00000", {busy, b_done, a_done, mem_write, mem_read});
        end
        n_tests++;
        if ({mem_addr, mem_din, a_rdata, b_rdata} !== 75'd0) begin
            n_fail++; $display("FAIL rstmid_outputs got addr=%h din=%h ard=%h brd=%h want 0", mem_addr, mem_din, a_rdata, b_rdata);
        end
        n_tests++;
        if ({mem[11'h200], mem[11'h201]} !== 32'h13579BDF) begin
            n_fail++; $display("FAIL rstmid_mem got %h_%h want 1357_9BDF", mem[11'h200], mem[11'h201]);
        end
        Rst = 0;
        @(posedge Clk); #1;
        n_tests++;
        if ({b_done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_after got done/busy=%b want 00", {b_done, busy});
        end
    endtask

    // Random traffic from both ports. Model: the arbiter samples whenever
    // the current cycle is at or past free_at; a grant at cycle t yields
    // done at t+2 (A) or t+3 (B) and frees the arbiter in that done cycle.
    task automatic test_random();
        int a_done_at, b_done_at, free_at, a_gap, b_gap;
        bit a_act, b_act, chk_a, chk_b, ae, be, pick_b, last_b;
        logic [15:0] exp_a;
        logic [31:0] exp_b;
        logic [10:0] lo;
        ref_mem.delete();
        do_reset();
        a_done_at = -1; b_done_at = -1; free_at = 0; a_gap = 0; b_gap = 0;
        a_act = 0; b_act = 0; chk_a = 0; chk_b = 0; last_b = 0;
        exp_a = '0; exp_b = '0;
        for (int t = 0; t < 600; t++) begin
            n_tests++;
            if (a_done !== (t == a_done_at)) begin
                n_fail++; $display("FAIL rnd_a_done t=%0d got %b want %b", t, a_done, (t == a_done_at));
            end
            n_tests++;
            if (b_done !== (t == b_done_at)) begin
                n_fail++; $display("FAIL rnd_b_done t=%0d got %b want %b", t, b_done, (t == b_done_at));
            end
            if (t == a_done_at && chk_a) begin
                n_tests++;
                if (a_rdata !== exp_a) begin n_fail++; $display("FAIL rnd_a_rdata t=%0d got %h want %h", t, a_rdata, exp_a); end
            end
            if (t == b_done_at && chk_b) begin
                n_tests++;
                if (b_rdata !== exp_b) begin n_fail++; $display("FAIL rnd_b_rdata t=%0d got %h want %h", t, b_rdata, exp_b); end
            end
            n_tests++;
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                n_fail++; $display("FAIL rnd_rd_wr_both t=%0d got 11 want not both", t);
            end

            // requesters
            if (a_act && t == a_done_at) begin
                a_req = 0; a_act = 0; a_gap = $urandom_range(0, 3);
            end else if (!a_act) begin
                if (a_gap > 0) a_gap--;
                else if (t < 560 && $urandom_range(0, 1) == 1) begin
                    a_req = 1; a_act = 1; a_we = $urandom_range(0, 1);
                    a_addr = 11'h7F9 + 11'($urandom_range(0, 7));
                    a_wdata = 16'($urandom);
                end
            end
            if (b_act && t == b_done_at) begin
                b_req = 0; b_act = 0; b_gap = $urandom_range(0, 3);
            end else if (!b_act) begin
                if (b_gap > 0) b_gap--;
                else if (t < 560 && $urandom_range(0, 1) == 1) begin
                    b_req = 1; b_act = 1; b_we = $urandom_range(0, 1);
                    b_addr = 11'h7F8 + 11'($urandom_range(0, 7));
                    b_wdata = $urandom;
                end
            end

            // model
            if (t >= free_at) begin
                ae = a_req && (t != a_done_at);
                be = b_req && (t != b_done_at);
`ifdef ARB_ROUND_ROBIN_EN
                pick_b = be && (!ae || !last_b);
`else
                pick_b = be;
`endif
                if (pick_b) begin
                    lo = b_addr + 11'd1;
                    if (b_we) begin
                        ref_mem[int'(b_addr)] = b_wdata[31:16];
                        ref_mem[int'(lo)]     = b_wdata[15:0];
                        chk_b = 0;
                    end else begin
                        chk_b = ref_mem.exists(int'(b_addr)) && ref_mem.exists(int'(lo));
                        if (chk_b) exp_b = {ref_mem[int'(b_addr)], ref_mem[int'(lo)]};
                    end
                    b_done_at = t + 3; free_at = t + 3; last_b = 1;
                end else if (ae) begin
                    if (a_we) begin
                        ref_mem[int'(a_addr)] = a_wdata;
                        chk_a = 0;
                    end else begin
                        chk_a = ref_mem.exists(int'(a_addr));
                        if (chk_a) exp_a = ref_mem[int'(a_addr)];
                    end
                    a_done_at = t + 2; free_at = t + 2; last_b = 0;
                end
            end
            @(posedge Clk); #1;
        end
        a_req = 0; b_req = 0;
        foreach (ref_mem[k]) begin
            n_tests++;
            if (mem[k] !== ref_mem[k]) begin
                n_fail++; $display("FAIL rnd_mem[%0h] got %h want %h", k, mem[k], ref_mem[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_a_store_load();
        test_b_push_pop();
        test_b_wrap();
        test_contention();
        test_reset_mid_push();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
